// File: rtl/copro_exec_scheduler_pkg.sv
// Shared coprocessor types: opcodes, scheduler state, queue entry and latency helpers.
package copro_exec_scheduler_pkg;

  // Decoded coprocessor opcodes as delivered by the decoder.
  typedef enum logic [3:0] {
    OP_NOP       = 4'h0,
    OP_ADD       = 4'h1,
    OP_SUB       = 4'h2,
    OP_XOR       = 4'h3,
    OP_ADD_MULTI = 4'h4,
    OP_ASCON     = 4'h5,
    OP_ILLEGAL   = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } sched_state_t;

  // Width of the id field stored in the issue queue. A scheduler built with a
  // different IdWidth casts into and out of this field.
  localparam int unsigned SCHED_ID_W = 4;

  typedef struct packed {
    opcode_t               opcode;
    logic [SCHED_ID_W-1:0] id;
    logic [4:0]            rd;
    logic                  we;
  } sched_entry_t;

  // Number of EXEC cycles an opcode occupies the datapath.
  function automatic int unsigned op_latency(opcode_t op, int unsigned multi_latency,
                                             int unsigned ascon_rounds);
    case (op)
      OP_ADD_MULTI: return multi_latency;
      OP_ASCON:     return ascon_rounds;
      default:      return 1;
    endcase
  endfunction

  // NOP and ILLEGAL produce no data and never write the register file.
  function automatic logic op_has_result(opcode_t op);
    return !((op == OP_NOP) || (op == OP_ILLEGAL));
  endfunction

endpackage

// File: rtl/copro_exec_scheduler_fifo.sv
// In-order issue queue of sched_entry_t with synchronous reset and clear.
module copro_sched_fifo
  import copro_exec_scheduler_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  sched_entry_t data_i,
  output sched_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  sched_entry_t    mem [Depth];
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic            do_push;
  logic            do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer update; clear empties the queue without touching storage.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/copro_exec_scheduler.sv
// Coprocessor execution scheduler: queues issued ops, drives the shared
// datapath for each op's latency and holds the result until accepted.
//
// state | meaning
// IDLE  | no op in flight; dispatch queue head when present
// EXEC  | datapath busy on op_q, cnt_q counts cycles/rounds
// WB    | result registered and presented until result_ready_i
module copro_exec_scheduler
  import copro_exec_scheduler_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned Depth        = 4,
  parameter int unsigned MultiLatency = 4,
  parameter int unsigned AsconRounds  = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [3:0]         issue_opcode_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [4:0]         issue_rd_i,
  input  logic               issue_we_i,
  output logic               exu_valid_o,
  output logic [3:0]         exu_opcode_o,
  output logic [IdWidth-1:0] exu_id_o,
  output logic [3:0]         exu_round_o,
  input  logic [XLEN-1:0]    exu_result_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o,
  output logic               result_err_o,
  output logic [XLEN-1:0]    result_data_o
);

  sched_state_t       state_q;
  sched_entry_t       op_q;
  logic [3:0]         cnt_q;
  logic [3:0]         last_cnt_q;

  sched_entry_t       fifo_in;
  sched_entry_t       fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [3:0]         head_last_cnt;
  logic               head_illegal;

  logic               exu_valid_q;
  logic [3:0]         exu_opcode_q;
  logic [IdWidth-1:0] exu_id_q;
  logic [3:0]         exu_round_q;

  logic               result_valid_q;
  logic [IdWidth-1:0] result_id_q;
  logic [4:0]         result_rd_q;
  logic               result_we_q;
  logic               result_err_q;
  logic [XLEN-1:0]    result_data_q;

  // Ready is held low while reset is asserted; no bypass, so full always blocks.
  assign issue_ready_o = !rst_i && !fifo_full;
  assign push          = issue_valid_i && issue_ready_o && !flush_i;

  // Dispatch from IDLE, or straight from WB on the result handshake.
  assign pop = !fifo_empty && !flush_i &&
               ((state_q == IDLE) || ((state_q == WB) && result_ready_i));

  assign fifo_in = '{opcode: opcode_t'(issue_opcode_i),
                     id:     SCHED_ID_W'(issue_id_i),
                     rd:     issue_rd_i,
                     we:     issue_we_i};

  assign head_last_cnt = 4'(op_latency(fifo_head.opcode, MultiLatency, AsconRounds) - 1);
  assign head_illegal  = (fifo_head.opcode == OP_ILLEGAL);

  copro_sched_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (fifo_in),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Scheduler FSM with round counter, datapath control and result register.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q        <= IDLE;
      op_q           <= '0;
      cnt_q          <= '0;
      last_cnt_q     <= '0;
      exu_valid_q    <= 1'b0;
      exu_opcode_q   <= '0;
      exu_id_q       <= '0;
      exu_round_q    <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_rd_q    <= '0;
      result_we_q    <= 1'b0;
      result_err_q   <= 1'b0;
      result_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        EXEC: begin
          if (cnt_q == last_cnt_q) begin
            state_q        <= WB;
            exu_valid_q    <= 1'b0;
            exu_opcode_q   <= '0;
            exu_id_q       <= '0;
            exu_round_q    <= '0;
            result_valid_q <= 1'b1;
            result_id_q    <= IdWidth'(op_q.id);
            result_rd_q    <= op_q.rd;
            result_we_q    <= op_q.we && op_has_result(op_q.opcode);
            result_err_q   <= (op_q.opcode == OP_ILLEGAL);
            result_data_q  <= op_has_result(op_q.opcode) ? exu_result_i : '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
            if (exu_valid_q) exu_round_q <= cnt_q + 4'd1;
          end
        end
        WB: begin
          if (result_ready_i) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_rd_q    <= '0;
            result_we_q    <= 1'b0;
            result_err_q   <= 1'b0;
            result_data_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A dispatch overrides the WB->IDLE fallback so back-to-back ops skip IDLE.
      if (pop) begin
        state_q      <= EXEC;
        op_q         <= fifo_head;
        cnt_q        <= '0;
        last_cnt_q   <= head_last_cnt;
        exu_valid_q  <= !head_illegal;
        exu_opcode_q <= head_illegal ? 4'd0 : fifo_head.opcode;
        exu_id_q     <= head_illegal ? '0 : IdWidth'(fifo_head.id);
        exu_round_q  <= '0;
      end
    end
  end

  assign exu_valid_o    = exu_valid_q;
  assign exu_opcode_o   = exu_opcode_q;
  assign exu_id_o       = exu_id_q;
  assign exu_round_o    = exu_round_q;
  assign result_valid_o = result_valid_q;
  assign result_id_o    = result_id_q;
  assign result_rd_o    = result_rd_q;
  assign result_we_o    = result_we_q;
  assign result_err_o   = result_err_q;
  assign result_data_o  = result_data_q;

endmodule

// File: doc/copro_exec_scheduler.md
Name: copro_exec_scheduler

Overview:
Sequences decoded CV-X-IF coprocessor instructions onto the shared coprocessor execution datapath and serializes their results onto the result interface.
- Accepted issue requests are buffered in an in-order queue.
- Each entry is dispatched to the datapath for an opcode-dependent number of cycles. OP_ASCON runs one round per cycle with a driven round index.
- The result is held until the core accepts it.
- Sits between the coprocessor decoder (issue side) and the datapath / CV-X-IF result port.

Parameters:
XLEN, 32, datapath/result width.
IdWidth, 4, instruction id width.
Depth, 4, issue queue entries (power of 2, at least 2).
MultiLatency, 4, EXEC cycles for ADD_MULTI (at least 1).
AsconRounds, 6, EXEC cycles and round count for OP_ASCON (1 to 12).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  kill all queued and in-flight instructions
issue_valid_i  in  1  issue request
issue_ready_o  out  1  queue can accept
issue_opcode_i  in  4  opcode_t from decoder
issue_id_i  in  IdWidth  instruction id
issue_rd_i  in  5  destination register
issue_we_i  in  1  writeback requested
exu_valid_o  out  1  datapath operating on current op this cycle
exu_opcode_o  out  4  opcode of current op
exu_id_o  out  IdWidth  id of current op
exu_round_o  out  4  cycle/round index within current op
exu_result_i  in  XLEN  datapath result, sampled on last EXEC cycle
result_valid_o  out  1  result available
result_ready_i  in  1  core accepts result
result_id_o  out  IdWidth  id
result_rd_o  out  5  destination register
result_we_o  out  1  write register file
result_err_o  out  1  illegal opcode retired
result_data_o  out  XLEN  result value

Behaviour:
- Synchronous active-high reset, as decided: one clock clk_i, synchronous active-high reset rst_i.
  - During and after reset all outputs are 0, except issue_ready_o = 1 from the first cycle after reset.
  - Queue is empty and the FSM is in IDLE.
  - Reset mid-operation discards everything and produces no result.
- Queue:
  - Push when issue_valid_i && issue_ready_o.
  - issue_ready_o = !full. There is no same-cycle bypass, so a full queue blocks even while popping.
  - Strict FIFO order; ids are retired in issue order.
- Per-opcode latency L:
  - ADD_MULTI: MultiLatency.
  - OP_ASCON: AsconRounds.
  - All other opcodes, including ILLEGAL: 1.
- FSM states IDLE, EXEC, WB:
  - IDLE: if the queue is non-empty, pop the head into the op register, set cnt = 0, go to EXEC.
  - EXEC: exu_valid_o = 1, except for ILLEGAL, where it stays 0. exu_round_o = cnt; cnt increments each cycle.
  - At cnt == L-1, register exu_result_i into result_data_o and go to WB. For NOP and ILLEGAL, data is 0.
  - WB: result_valid_o = 1; all result fields are stable until the handshake.
  - On result_ready_i in WB: if the queue is non-empty, pop and go to EXEC (back-to-back), else go to IDLE.
- Result fields:
  - result_we_o = issue_we_i && opcode not NOP/ILLEGAL.
  - result_err_o = (opcode == ILLEGAL).
- Latency: issue handshake at cycle t with an empty, idle scheduler gives result_valid_o at t+L+2. Steady-state throughput is one op per L+1 cycles.
- exu_* outputs are 0 whenever exu_valid_o = 0.
- flush_i, synchronous, same cycle effect at the next edge:
  - Queue is emptied; FSM goes to IDLE; result_valid_o drops.
  - An issue handshake in the same cycle is discarded.
  - flush_i has priority over result_ready_i.
- cnt is 4 bits and never wraps: it is only compared against L-1, and L ≤ 12.

Decomposition:
- Add to the shared coprocessor package:
  - sched_state_t enum (IDLE, EXEC, WB).
  - sched_entry_t packed struct {opcode_t opcode; id; rd; we}.
  - Function op_latency(opcode_t) returning L from the parameters.
- One sub-module: copro_sched_fifo, a parameterized synchronous-reset FIFO of sched_entry_t with push/pop/full/empty.
- The FSM, round counter and result register live in copro_exec_scheduler.

Test Plan:
- ADD: id=3, rd=5, we=1, exu_result_i=0x00000007 → exu_valid_o high for one cycle with exu_round_o=0; result_valid_o at t+3 with id=3, rd=5, we=1, err=0, data=0x7.
- OP_ASCON with AsconRounds=6 → exu_round_o = 0,1,2,3,4,5 on consecutive cycles; data sampled at round 5; result at t+8.
- result_ready_i=0, issue ADD ids 0..6 back-to-back with Depth=4 → ids 0..4 accepted; issue_ready_o low from the cycle after id 4. Releasing ready retires ids 0..4 in order, one every 2 cycles.
- Flush while OP_ASCON is at round 3 with 2 queued → next cycle exu_valid_o=0, no result_valid_o, issue_ready_o=1; a following ADD completes normally.
- NOP (we=1) gives a result with we=0, err=0, data=0. ILLEGAL gives we=0, err=1, and exu_valid_o is never asserted.
- rst_i asserted during EXEC of ADD_MULTI and during WB with result_ready_i=0 → all outputs 0 and no stale result afterwards.
